collision_scheduler: RTL and testbench
======================================

COLLISION_SCHEDULER -- requirements
Module: collision_scheduler

Interface
REQ-001 Parameters (name, default, meaning):
  NUM_POINTS 8, number of car mass points sequenced per frame.
  POSITION_SIZE 15, signed position width.
  VELOCITY_SIZE 10, signed velocity width.
  FORCE_SIZE 8, signed per-point force width.
  TIMEOUT_CYCLES 1024, maximum WAIT cycles per point.
REQ-002 One clock; reset is asynchronous and active-low.
REQ-003 Ports (name, direction, width, meaning):
  clk_in  in  1  system clock.
  rst_in  in  1  async active-low reset.
  frame_start_in  in  1  one-cycle pulse, starts a frame.
  load_valid_in  in  1  write one point's initial state.
  load_idx_in  in  $clog2(NUM_POINTS)  point index for load.
  load_pos_x_in, load_pos_y_in  in  POSITION_SIZE each  load position.
  load_vel_x_in, load_vel_y_in  in  VELOCITY_SIZE each  load velocity.
  eng_begin_out  out  1  begin pulse to collision engine.
  eng_pos_x_out, eng_pos_y_out  out  POSITION_SIZE each  current point position to engine.
  eng_vel_x_out, eng_vel_y_out  out  VELOCITY_SIZE each  current point velocity to engine.
  eng_result_in  in  1  engine result valid.
  eng_new_pos_x_in, eng_new_pos_y_in  in  POSITION_SIZE each  engine position result.
  eng_new_vel_x_in, eng_new_vel_y_in  in  VELOCITY_SIZE each  engine velocity result.
  eng_force_x_in, eng_force_y_in  in  FORCE_SIZE each  engine contact force.
  rd_idx_in  in  $clog2(NUM_POINTS)  readback index.
  rd_pos_x_out, rd_pos_y_out  out  POSITION_SIZE each  combinational readback of stored position.
  acc_force_x_out, acc_force_y_out  out  FORCE_SIZE+$clog2(NUM_POINTS)  frame force sums.
  busy_out  out  1  high in any state other than IDLE.
  frame_done_out  out  1  one-cycle pulse at frame end.
  timeout_err_out  out  1  sticky engine-timeout flag.
  overrun_err_out  out  1  sticky flag: frame_start while busy.

Function
REQ-004 State register SHALL hold one of IDLE, ISSUE, WAIT, DONE; point state SHALL live in a NUM_POINTS-entry register file (pos_x, pos_y, vel_x, vel_y).
REQ-005 IDLE: frame_start_in=1 SHALL clear acc_force_x/y to 0, set idx=0, and go to ISSUE on the next edge.
REQ-006 ISSUE SHALL last exactly one cycle with eng_begin_out=1, then go to WAIT; eng_begin_out SHALL be 0 in all other states.
REQ-007 eng_pos/vel outputs SHALL be registered copies of regfile[idx], valid from the ISSUE cycle and held constant through WAIT.
REQ-008 WAIT SHALL ignore eng_result_in in its first cycle (stale-level guard) and sample it from the second cycle on.
REQ-009 On a sampled eng_result_in=1, the block SHALL write eng_new_* into regfile[idx] and add sign-extended eng_force_* into acc_force_*, all on the same edge.
REQ-010 After the write: if idx==NUM_POINTS-1, go to DONE; else increment idx and go to ISSUE. Engine latency to next begin SHALL be exactly 1 cycle.
REQ-011 A WAIT counter SHALL reset on ISSUE; on reaching TIMEOUT_CYCLES without result, set timeout_err_out, leave regfile[idx] and acc unchanged, and advance as in REQ-010.
REQ-012 DONE SHALL assert frame_done_out for exactly one cycle, then return to IDLE.
REQ-013 Accumulators SHALL be wide enough never to overflow (NUM_POINTS x FORCE_SIZE signed); no saturation.
REQ-014 load_valid_in SHALL write the regfile only in IDLE; loads when busy SHALL be dropped silently.
REQ-015 Simultaneous load_valid_in and frame_start_in in IDLE SHALL apply the load, and the frame SHALL use the loaded value.
REQ-016 frame_start_in while busy SHALL be ignored and SHALL set overrun_err_out.
REQ-017 Sticky flags SHALL clear only on reset.

Reset
REQ-018 rst_in=0 SHALL asynchronously force: state=IDLE, idx=0, all regfile entries 0, acc_force_*=0, all error flags 0, and eng_begin_out, frame_done_out, busy_out, and eng_* outputs 0.
REQ-019 Reset mid-frame SHALL abort the frame with no frame_done_out; the first frame_start_in after release SHALL start from idx=0.

Verification
REQ-020 NUM_POINTS=2: load pt0 (-4,-7,5,-6); start frame; engine answers 3 cycles after each begin with pt0 new=(1,-13,5,-6), force (2,-3), and pt1 force (-1,4). Required: exactly two begin pulses, regfile updated, acc=(1,1), one frame_done_out, busy_out low afterwards.
REQ-021 Engine holds eng_result_in=1 constantly. Required: result is not taken in the first WAIT cycle; each point is consumed on the second WAIT cycle.
REQ-022 Engine never responds, TIMEOUT_CYCLES=16. Required: each point times out after 16 cycles, timeout_err_out=1, regfile unchanged, frame_done_out still pulses.
REQ-023 frame_start_in and load_valid_in pulsed mid-frame. Required: overrun_err_out=1, load dropped, frame unaffected.
REQ-024 rst_in low during WAIT of pt1. Required: outputs immediately match reset values; the next frame issues pt0 first.

Source files
------------

// File: rtl/collision_scheduler_if.sv
// rtl/collision_scheduler_if.sv - handshake bundle between the frame scheduler and the collision engine
interface collision_scheduler_if #(
    parameter int POSITION_SIZE = 15,
    parameter int VELOCITY_SIZE = 10,
    parameter int FORCE_SIZE    = 8
);
    logic                            eng_begin_out;
    logic signed [POSITION_SIZE-1:0] eng_pos_x_out;
    logic signed [POSITION_SIZE-1:0] eng_pos_y_out;
    logic signed [VELOCITY_SIZE-1:0] eng_vel_x_out;
    logic signed [VELOCITY_SIZE-1:0] eng_vel_y_out;
    logic                            eng_result_in;
    logic signed [POSITION_SIZE-1:0] eng_new_pos_x_in;
    logic signed [POSITION_SIZE-1:0] eng_new_pos_y_in;
    logic signed [VELOCITY_SIZE-1:0] eng_new_vel_x_in;
    logic signed [VELOCITY_SIZE-1:0] eng_new_vel_y_in;
    logic signed [FORCE_SIZE-1:0]    eng_force_x_in;
    logic signed [FORCE_SIZE-1:0]    eng_force_y_in;

    modport master (
        output eng_begin_out, eng_pos_x_out, eng_pos_y_out, eng_vel_x_out, eng_vel_y_out,
        input  eng_result_in, eng_new_pos_x_in, eng_new_pos_y_in,
               eng_new_vel_x_in, eng_new_vel_y_in, eng_force_x_in, eng_force_y_in
    );

    modport slave (
        input  eng_begin_out, eng_pos_x_out, eng_pos_y_out, eng_vel_x_out, eng_vel_y_out,
        output eng_result_in, eng_new_pos_x_in, eng_new_pos_y_in,
               eng_new_vel_x_in, eng_new_vel_y_in, eng_force_x_in, eng_force_y_in
    );
endinterface

// File: rtl/collision_scheduler.sv
// rtl/collision_scheduler.sv - sequences each stored mass point through the collision engine once per frame
// and accumulates the returned contact forces.
module collision_scheduler #(
    parameter int NUM_POINTS     = 8,
    parameter int POSITION_SIZE  = 15,
    parameter int VELOCITY_SIZE  = 10,
    parameter int FORCE_SIZE     = 8,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                                              clk_in,
    input  logic                                              rst_in,
    input  logic                                              frame_start_in,
    input  logic                                              load_valid_in,
    input  logic        [$clog2(NUM_POINTS)-1:0]              load_idx_in,
    input  logic signed [POSITION_SIZE-1:0]                   load_pos_x_in,
    input  logic signed [POSITION_SIZE-1:0]                   load_pos_y_in,
    input  logic signed [VELOCITY_SIZE-1:0]                   load_vel_x_in,
    input  logic signed [VELOCITY_SIZE-1:0]                   load_vel_y_in,
    collision_scheduler_if.master                             eng_if,
    input  logic        [$clog2(NUM_POINTS)-1:0]              rd_idx_in,
    output logic signed [POSITION_SIZE-1:0]                   rd_pos_x_out,
    output logic signed [POSITION_SIZE-1:0]                   rd_pos_y_out,
    output logic signed [FORCE_SIZE+$clog2(NUM_POINTS)-1:0]   acc_force_x_out,
    output logic signed [FORCE_SIZE+$clog2(NUM_POINTS)-1:0]   acc_force_y_out,
    output logic                                              busy_out,
    output logic                                              frame_done_out,
    output logic                                              timeout_err_out,
    output logic                                              overrun_err_out
);
    localparam int IW = $clog2(NUM_POINTS);
    localparam int AW = FORCE_SIZE + IW;
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(NUM_POINTS - 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

    state_t                     state_q, state_d;
    logic [IW-1:0]              idx_q, idx_d;
    logic [CW-1:0]              cnt_q, cnt_d;
    logic signed [POSITION_SIZE-1:0] pos_x_q [NUM_POINTS];
    logic signed [POSITION_SIZE-1:0] pos_y_q [NUM_POINTS];
    logic signed [VELOCITY_SIZE-1:0] vel_x_q [NUM_POINTS];
    logic signed [VELOCITY_SIZE-1:0] vel_y_q [NUM_POINTS];
    logic signed [AW-1:0]       acc_x_q, acc_y_q;
    logic signed [POSITION_SIZE-1:0] eng_pos_x_q, eng_pos_y_q;
    logic signed [VELOCITY_SIZE-1:0] eng_vel_x_q, eng_vel_y_q;
    logic                       timeout_q, overrun_q;
    logic                       start, take, expire, fetch, load_en, bypass;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        start   = 1'b0;
        take    = 1'b0;
        expire  = 1'b0;
        fetch   = 1'b0;
        load_en = load_valid_in && (state_q == IDLE);
        case (state_q)
            IDLE: begin
                if (frame_start_in) begin
                    start   = 1'b1;
                    fetch   = 1'b1;
                    idx_d   = '0;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                cnt_d   = '0;
                state_d = WAIT;
            end
            WAIT: begin
                // the first WAIT cycle may still see the previous point's result level
                take   = eng_if.eng_result_in && (cnt_q != '0);
                expire = !take && (cnt_q == CNT_LAST);
                cnt_d  = cnt_q + 1'b1;
                if (take || expire) begin
                    if (idx_q == IDX_LAST) begin
                        state_d = DONE;
                    end else begin
                        idx_d   = idx_q + 1'b1;
                        fetch   = 1'b1;
                        state_d = ISSUE;
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        // a load landing on the same edge as frame start must reach the engine copy
        bypass = load_en && (load_idx_in == idx_d);
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            cnt_q       <= '0;
            acc_x_q     <= '0;
            acc_y_q     <= '0;
            eng_pos_x_q <= '0;
            eng_pos_y_q <= '0;
            eng_vel_x_q <= '0;
            eng_vel_y_q <= '0;
            timeout_q   <= 1'b0;
            overrun_q   <= 1'b0;
            for (int i = 0; i < NUM_POINTS; i++) begin
                pos_x_q[i] <= '0;
                pos_y_q[i] <= '0;
                vel_x_q[i] <= '0;
                vel_y_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            if (load_en) begin
                pos_x_q[load_idx_in] <= load_pos_x_in;
                pos_y_q[load_idx_in] <= load_pos_y_in;
                vel_x_q[load_idx_in] <= load_vel_x_in;
                vel_y_q[load_idx_in] <= load_vel_y_in;
            end
            if (take) begin
                pos_x_q[idx_q] <= eng_if.eng_new_pos_x_in;
                pos_y_q[idx_q] <= eng_if.eng_new_pos_y_in;
                vel_x_q[idx_q] <= eng_if.eng_new_vel_x_in;
                vel_y_q[idx_q] <= eng_if.eng_new_vel_y_in;
                acc_x_q <= acc_x_q + {{IW{eng_if.eng_force_x_in[FORCE_SIZE-1]}}, eng_if.eng_force_x_in};
                acc_y_q <= acc_y_q + {{IW{eng_if.eng_force_y_in[FORCE_SIZE-1]}}, eng_if.eng_force_y_in};
            end
            if (start) begin
                acc_x_q <= '0;
                acc_y_q <= '0;
            end
            if (fetch) begin
                eng_pos_x_q <= bypass ? load_pos_x_in : pos_x_q[idx_d];
                eng_pos_y_q <= bypass ? load_pos_y_in : pos_y_q[idx_d];
                eng_vel_x_q <= bypass ? load_vel_x_in : vel_x_q[idx_d];
                eng_vel_y_q <= bypass ? load_vel_y_in : vel_y_q[idx_d];
            end
            if (expire) timeout_q <= 1'b1;
            if (frame_start_in && (state_q != IDLE)) overrun_q <= 1'b1;
        end
    end

    assign eng_if.eng_begin_out = (state_q == ISSUE);
    assign eng_if.eng_pos_x_out = eng_pos_x_q;
    assign eng_if.eng_pos_y_out = eng_pos_y_q;
    assign eng_if.eng_vel_x_out = eng_vel_x_q;
    assign eng_if.eng_vel_y_out = eng_vel_y_q;

    assign rd_pos_x_out    = pos_x_q[rd_idx_in];
    assign rd_pos_y_out    = pos_y_q[rd_idx_in];
    assign acc_force_x_out = acc_x_q;
    assign acc_force_y_out = acc_y_q;
    assign busy_out        = (state_q != IDLE);
    assign frame_done_out  = (state_q == DONE);
    assign timeout_err_out = timeout_q;
    assign overrun_err_out = overrun_q;
endmodule

// File: tb/tb_collision_scheduler.sv
// tb/tb_collision_scheduler.sv - frame-level bench: point-by-point model of issue timing, results, forces and flags
module tb_collision_scheduler;
    localparam int NP = 2;
    localparam int PW = 15;
    localparam int VW = 10;
    localparam int FW = 8;
    localparam int TO = 16;
    localparam int IW = 1;
    localparam int AW = FW + IW;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b1;
    logic                 frame_start, load_valid;
    logic        [IW-1:0] load_idx, rd_idx;
    logic signed [PW-1:0] load_px, load_py, rd_px, rd_py;
    logic signed [VW-1:0] load_vx, load_vy;
    logic signed [AW-1:0] acc_x, acc_y;
    logic                 busy, done, to_err, ov_err;

    collision_scheduler_if #(.POSITION_SIZE(PW), .VELOCITY_SIZE(VW), .FORCE_SIZE(FW)) eng ();

    collision_scheduler #(
        .NUM_POINTS(NP), .POSITION_SIZE(PW), .VELOCITY_SIZE(VW),
        .FORCE_SIZE(FW), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk_in(clk), .rst_in(rst_n), .frame_start_in(frame_start),
        .load_valid_in(load_valid), .load_idx_in(load_idx),
        .load_pos_x_in(load_px), .load_pos_y_in(load_py),
        .load_vel_x_in(load_vx), .load_vel_y_in(load_vy),
        .eng_if(eng), .rd_idx_in(rd_idx),
        .rd_pos_x_out(rd_px), .rd_pos_y_out(rd_py),
        .acc_force_x_out(acc_x), .acc_force_y_out(acc_y),
        .busy_out(busy), .frame_done_out(done),
        .timeout_err_out(to_err), .overrun_err_out(ov_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int m_px[NP], m_py[NP], m_vx[NP], m_vy[NP];
    int m_ax, m_ay, m_to, m_ov;
    int cfg_lat[NP];
    bit cfg_hold, cfg_fixed;
    int fx_px[NP], fx_py[NP], fx_vx[NP], fx_vy[NP], fx_fx[NP], fx_fy[NP];

    task automatic chk(input string tag, input longint obs, input longint exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int rnd(input int w);
        return int'($urandom_range(0, (1 << w) - 1)) - (1 << (w - 1));
    endfunction

    task automatic eng_drive(input bit r);
        eng.eng_result_in    = r;
        eng.eng_new_pos_x_in = PW'(rnd(PW));
        eng.eng_new_pos_y_in = PW'(rnd(PW));
        eng.eng_new_vel_x_in = VW'(rnd(VW));
        eng.eng_new_vel_y_in = VW'(rnd(VW));
        eng.eng_force_x_in   = FW'(rnd(FW));
        eng.eng_force_y_in   = FW'(rnd(FW));
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_begin", eng.eng_begin_out, 0);
        chk("rst_eng_pos_x", eng.eng_pos_x_out, 0);
        chk("rst_eng_pos_y", eng.eng_pos_y_out, 0);
        chk("rst_eng_vel_x", eng.eng_vel_x_out, 0);
        chk("rst_eng_vel_y", eng.eng_vel_y_out, 0);
        chk("rst_acc_x", acc_x, 0);
        chk("rst_acc_y", acc_y, 0);
        chk("rst_timeout", to_err, 0);
        chk("rst_overrun", ov_err, 0);
        chk("rst_rd_pos_x", rd_px, 0);
        for (int i = 0; i < NP; i++) begin
            m_px[i] = 0; m_py[i] = 0; m_vx[i] = 0; m_vy[i] = 0;
        end
        m_ax = 0; m_ay = 0; m_to = 0; m_ov = 0;
        frame_start = 1'b0;
        load_valid  = 1'b0;
        eng_drive(1'b0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic do_load(input int i, input int px, input int py, input int vx, input int vy);
        load_valid = 1'b1;
        load_idx = IW'(i);
        load_px = PW'(px); load_py = PW'(py); load_vx = VW'(vx); load_vy = VW'(vy);
        m_px[i] = px; m_py[i] = py; m_vx[i] = vx; m_vy[i] = vy;
        @(negedge clk);
        load_valid = 1'b0;
    endtask

    // ld: load issued together with frame_start; ov_pt/rst_pt: point whose WAIT gets a
    // mid-frame start+load (c==1) or a reset (c==2); -1 disables.
    task automatic run_frame(input bit ld, input int ld_i, input int ov_pt, input int rst_pt);
        int lx, ly, lvx, lvy, ipx, ipy, ivx, ivy, acc_w, gap;
        lx = rnd(PW); ly = rnd(PW); lvx = rnd(VW); lvy = rnd(VW);
        frame_start = 1'b1;
        load_valid = ld;
        load_idx = IW'(ld_i);
        load_px = PW'(lx); load_py = PW'(ly); load_vx = VW'(lvx); load_vy = VW'(lvy);
        if (ld) begin
            m_px[ld_i] = lx; m_py[ld_i] = ly; m_vx[ld_i] = lvx; m_vy[ld_i] = lvy;
        end
        m_ax = 0; m_ay = 0;
        eng_drive(cfg_hold);
        @(negedge clk);
        frame_start = 1'b0;
        load_valid = 1'b0;
        for (int k = 0; k < NP; k++) begin
            chk("issue_begin", eng.eng_begin_out, 1);
            chk("issue_busy", busy, 1);
            chk("issue_pos_x", eng.eng_pos_x_out, m_px[k]);
            chk("issue_pos_y", eng.eng_pos_y_out, m_py[k]);
            chk("issue_vel_x", eng.eng_vel_x_out, m_vx[k]);
            chk("issue_vel_y", eng.eng_vel_y_out, m_vy[k]);
            ipx = m_px[k]; ipy = m_py[k]; ivx = m_vx[k]; ivy = m_vy[k];
            if (cfg_hold) acc_w = 1;
            else if (cfg_lat[k] >= 2 && cfg_lat[k] <= TO) acc_w = cfg_lat[k] - 1;
            else acc_w = -1;
            gap = (acc_w >= 0) ? acc_w + 2 : TO + 1;
            eng_drive(cfg_hold);
            for (int c = 1; c < gap; c++) begin
                @(negedge clk);
                chk("wait_begin", eng.eng_begin_out, 0);
                chk("wait_hold_pos_x", eng.eng_pos_x_out, ipx);
                chk("wait_hold_vel_y", eng.eng_vel_y_out, ivy);
                if (k == rst_pt && c == 2) begin
                    apply_reset();
                    return;
                end
                eng_drive(cfg_hold || cfg_lat[k] == c);
                if (c - 1 == acc_w) begin
                    if (cfg_fixed) begin
                        eng.eng_new_pos_x_in = PW'(fx_px[k]);
                        eng.eng_new_pos_y_in = PW'(fx_py[k]);
                        eng.eng_new_vel_x_in = VW'(fx_vx[k]);
                        eng.eng_new_vel_y_in = VW'(fx_vy[k]);
                        eng.eng_force_x_in   = FW'(fx_fx[k]);
                        eng.eng_force_y_in   = FW'(fx_fy[k]);
                    end
                    m_px[k] = int'(eng.eng_new_pos_x_in);
                    m_py[k] = int'(eng.eng_new_pos_y_in);
                    m_vx[k] = int'(eng.eng_new_vel_x_in);
                    m_vy[k] = int'(eng.eng_new_vel_y_in);
                    m_ax += int'(eng.eng_force_x_in);
                    m_ay += int'(eng.eng_force_y_in);
                end
                frame_start = (k == ov_pt && c == 1);
                load_valid = frame_start;
                load_idx = IW'(k);
                load_px = PW'(rnd(PW)); load_py = PW'(rnd(PW));
                load_vx = VW'(rnd(VW)); load_vy = VW'(rnd(VW));
                if (k == ov_pt && c == 1) m_ov = 1;
            end
            if (acc_w < 0) m_to = 1;
            @(negedge clk);
            frame_start = 1'b0;
            load_valid = 1'b0;
        end
        chk("done_pulse", done, 1);
        chk("done_begin", eng.eng_begin_out, 0);
        eng_drive(1'b0);
        @(negedge clk);
        chk("done_single", done, 0);
        chk("idle_busy", busy, 0);
        chk("acc_x", acc_x, m_ax);
        chk("acc_y", acc_y, m_ay);
        chk("timeout_flag", to_err, m_to);
        chk("overrun_flag", ov_err, m_ov);
        for (int i = 0; i < NP; i++) begin
            rd_idx = IW'(i);
            #1;
            chk("rd_pos_x", rd_px, m_px[i]);
            chk("rd_pos_y", rd_py, m_py[i]);
        end
    endtask

    initial begin
        frame_start = 1'b0; load_valid = 1'b0; load_idx = '0; rd_idx = '0;
        load_px = '0; load_py = '0; load_vx = '0; load_vy = '0;
        cfg_hold = 1'b0; cfg_fixed = 1'b0;
        eng_drive(1'b0);
        #2;
        apply_reset();

        do_load(0, -4, -7, 5, -6);
        cfg_fixed = 1'b1;
        fx_px = '{1, 7};  fx_py = '{-13, 8}; fx_vx = '{5, -9}; fx_vy = '{-6, 10};
        fx_fx = '{2, -1}; fx_fy = '{-3, 4};
        cfg_lat = '{3, 3};
        run_frame(1'b0, 0, -1, -1);
        chk("two_pt_acc_x", acc_x, 1);
        chk("two_pt_acc_y", acc_y, 1);
        cfg_fixed = 1'b0;

        cfg_hold = 1'b1;
        run_frame(1'b1, 1, -1, -1);
        cfg_hold = 1'b0;

        cfg_lat = '{0, 0};
        run_frame(1'b0, 0, -1, -1);

        cfg_lat = '{4, 5};
        run_frame(1'b0, 0, 0, -1);

        for (int f = 0; f < 10; f++) begin
            for (int i = 0; i < NP; i++) cfg_lat[i] = int'($urandom_range(0, TO));
            cfg_hold = ($urandom_range(0, 3) == 0);
            run_frame(1'($urandom_range(0, 1)), int'($urandom_range(0, NP - 1)), -1, -1);
        end
        cfg_hold = 1'b0;

        cfg_lat = '{3, 6};
        run_frame(1'b0, 0, -1, 1);
        do_load(0, rnd(PW), rnd(PW), rnd(VW), rnd(VW));
        do_load(1, rnd(PW), rnd(PW), rnd(VW), rnd(VW));
        cfg_lat = '{2, 3};
        run_frame(1'b0, 0, -1, -1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
